// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port main-memory arbiter.
package mem_arb_pkg;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    localparam int BURST_LEN = 4;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the pointer advances only when the owner completes.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic owner,
    output logic gnt_vld,
    output logic gnt_port
);
    import mem_arb_pkg::*;

    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        gnt_vld  = req0 | req1;
        gnt_port = (req0 & req1) ? rr_ptr_q : (req1 ? PORT_I : PORT_D);
        rr_ptr_d = upd ? ~owner : rr_ptr_q;
    end

    always_ff @(negedge clk) begin
        if (rst) rr_ptr_q <= PORT_D;
        else     rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the D-cache controller (port 0) and the
// I-cache refill engine (port 1); single reads, 4-word bursts, single writes.
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              burst0,
    input  logic              burst1,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        word_idx,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_Adr,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import mem_arb_pkg::*;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);
    localparam logic [3:0] CNT_WE   = 4'(MEM_LAT - 2);
    localparam logic [1:0] WORD_LAST = 2'(BURST_LEN - 1);

    logic [0:0]        state_q, state_d;
    logic              owner_q, owner_d, we_q, we_d, burst_q, burst_d;
    logic [ADDR_W-1:0] adr_q, adr_d, mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        word_q, word_d, word_idx_q, word_idx_d, word_nxt;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              busy_q, busy_d, mem_we_q, mem_we_d;
    logic              gnt_vld, gnt_port, upd;
    logic              we_s, burst_s;
    logic [ADDR_W-1:0] adr_s;
    logic [DATA_W-1:0] wdata_s;

    rr_arbiter2 u_rr (
        .clk      (CLK),
        .rst      (RST),
        .req0     (req0),
        .req1     (req1),
        .upd      (upd),
        .owner    (owner_q),
        .gnt_vld  (gnt_vld),
        .gnt_port (gnt_port)
    );

    assign word_nxt = word_q + 2'd1;

    always_comb begin
        we_s    = gnt_port ? we1    : we0;
        burst_s = gnt_port ? burst1 : burst0;
        adr_s   = gnt_port ? adr1   : adr0;
        wdata_s = gnt_port ? wdata1 : wdata0;

        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        burst_d     = burst_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        rdata_d     = rdata_q;
        word_idx_d  = word_idx_q;
        busy_d      = busy_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        upd         = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d     = gnt_port;
                    we_d        = we_s;
                    burst_d     = burst_s & ~we_s;
                    adr_d       = adr_s;
                    wdata_d     = wdata_s;
                    gnt0_d      = ~gnt_port;
                    gnt1_d      = gnt_port;
                    state_d     = ACCESS;
                    busy_d      = 1'b1;
                    cnt_d       = 4'd0;
                    word_d      = 2'd0;
                    mem_adr_d   = (burst_s & ~we_s) ? {adr_s[ADDR_W-1:2], 2'b00} : adr_s;
                    mem_wdata_d = wdata_s;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                // Write strobe occupies the final cycle of the access window.
                if (we_q && cnt_q == CNT_WE) mem_we_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (!we_q) begin
                        rdata_d    = mem_rdata;
                        word_idx_d = burst_q ? word_q : adr_q[1:0];
                        rvalid0_d  = ~owner_q;
                        rvalid1_d  = owner_q;
                    end
                    if (burst_q && word_q != WORD_LAST) begin
                        word_d    = word_nxt;
                        cnt_d     = 4'd0;
                        mem_adr_d = {adr_q[ADDR_W-1:2], word_nxt};
                    end else begin
                        done0_d = ~owner_q;
                        done1_d = owner_q;
                        busy_d  = 1'b0;
                        upd     = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            owner_q     <= PORT_D;
            we_q        <= 1'b0;
            burst_q     <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= 4'd0;
            word_q      <= 2'd0;
            rdata_q     <= '0;
            word_idx_q  <= 2'd0;
            busy_q      <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            burst_q     <= burst_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            rdata_q     <= rdata_d;
            word_idx_q  <= word_idx_d;
            busy_q      <= busy_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign word_idx  = word_idx_q;
    assign busy      = busy_q;
    assign mem_Adr   = mem_adr_q;
    assign mem_WE    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=4). DUT updates on the falling
// edge; the bench drives and samples on the rising edge.
module tb_mem_port_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic        req0, req1, we0, we1, burst0, burst1;
    logic [9:0]  adr0, adr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, done0, done1, busy, mem_WE;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [1:0]  word_idx;
    logic [9:0]  mem_Adr;
    logic        mem_sel;
    int          errors = 0;
    int          checks = 0;

    always #5 CLK = ~CLK;

    // Memory model: fixed word, or an address-tagged pattern.
    always_comb mem_rdata = mem_sel ? (32'hA5A50000 | {22'd0, mem_Adr}) : 32'hCAFE0001;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(4)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .burst0(burst0), .burst1(burst1), .adr0(adr0), .adr1(adr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .done0(done0), .done1(done1), .rdata(rdata), .word_idx(word_idx),
        .busy(busy), .mem_Adr(mem_Adr), .mem_WE(mem_WE),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_gnt"},   {30'd0, gnt1, gnt0}, 32'd0);
        chk({tag, "_rv"},    {30'd0, rvalid1, rvalid0}, 32'd0);
        chk({tag, "_done"},  {30'd0, done1, done0}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_widx"},  {30'd0, word_idx}, 32'd0);
        chk({tag, "_madr"},  {22'd0, mem_Adr}, 32'd0);
        chk({tag, "_mwe"},   {31'd0, mem_WE}, 32'd0);
        chk({tag, "_mwd"},   mem_wdata, 32'd0);
    endtask

    initial begin
        RST = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; burst0 = 0; burst1 = 0;
        adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0; mem_sel = 0;
        step(); step(); step();
        chk_all_zero("reset");
        RST = 1'b0;
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Contention right after reset: port 0 first, port 1 at E5.
        req0 = 1; req1 = 1; adr0 = 10'h010; adr1 = 10'h020;
        step();
        chk("cont_gnt0", {31'd0, gnt0}, 32'd1);
        chk("cont_gnt1", {31'd0, gnt1}, 32'd0);
        req0 = 0;
        step(); step(); step(); step();
        chk("cont_done0", {31'd0, done0}, 32'd1);
        chk("cont_gnt1_wait", {31'd0, gnt1}, 32'd0);
        step();
        chk("cont_gnt1_e5", {31'd0, gnt1}, 32'd1);
        req1 = 0;
        step(); step(); step(); step();
        chk("cont_done1", {31'd0, done1}, 32'd1);
        req0 = 1; req1 = 1;
        step();
        chk("cont2_gnt0", {31'd0, gnt0}, 32'd1);
        chk("cont2_gnt1", {31'd0, gnt1}, 32'd0);
        req0 = 0;
        step(); step(); step(); step(); step();
        chk("cont2_gnt1_e5", {31'd0, gnt1}, 32'd1);
        req1 = 0;
        step(); step(); step(); step();
        chk("cont2_done1", {31'd0, done1}, 32'd1);

        // Single read from port 0.
        req0 = 1; adr0 = 10'h2D3;
        step();
        chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rd_madr_e0", {22'd0, mem_Adr}, 32'h2D3);
        req0 = 0;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("rd_rv_early", {31'd0, rvalid0}, 32'd0);
            chk("rd_madr_hold", {22'd0, mem_Adr}, 32'h2D3);
        end
        step();
        chk("rd_rv", {31'd0, rvalid0}, 32'd1);
        chk("rd_done", {31'd0, done0}, 32'd1);
        chk("rd_data", rdata, 32'hCAFE0001);
        chk("rd_widx", {30'd0, word_idx}, 32'd3);
        chk("rd_busy", {31'd0, busy}, 32'd0);
        chk("rd_madr_e4", {22'd0, mem_Adr}, 32'h2D3);
        step();
        chk("rd_rv_pulse", {30'd0, rvalid0, done0}, 32'd0);
        chk("rd_data_hold", rdata, 32'hCAFE0001);

        // Burst read from port 1, adr[1:0] ignored.
        mem_sel = 1; req1 = 1; burst1 = 1; adr1 = 10'h1A6;
        step();
        chk("bu_gnt1", {31'd0, gnt1}, 32'd1);
        chk("bu_madr0", {22'd0, mem_Adr}, 32'h1A4);
        req1 = 0; burst1 = 0;
        for (int w = 0; w < 4; w++) begin
            for (int c = 1; c <= 4; c++) begin
                step();
                if (c < 4) begin
                    chk("bu_rv_early", {31'd0, rvalid1}, 32'd0);
                    chk("bu_madr", {22'd0, mem_Adr}, 32'h1A4 + w);
                end else begin
                    chk("bu_rv", {31'd0, rvalid1}, 32'd1);
                    chk("bu_widx", {30'd0, word_idx}, w);
                    chk("bu_data", rdata, 32'hA5A501A4 + w);
                    chk("bu_done", {31'd0, done1}, (w == 3) ? 32'd1 : 32'd0);
                end
            end
        end
        mem_sel = 0;

        // Write from port 0.
        req0 = 1; we0 = 1; adr0 = 10'h055; wdata0 = 32'h12345678;
        step();
        chk("wr_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 0;
        step();
        chk("wr_we_e1", {31'd0, mem_WE}, 32'd0);
        step();
        chk("wr_we_e2", {31'd0, mem_WE}, 32'd0);
        step();
        chk("wr_we_e3", {31'd0, mem_WE}, 32'd1);
        chk("wr_madr", {22'd0, mem_Adr}, 32'h055);
        chk("wr_mwd", mem_wdata, 32'h12345678);
        step();
        chk("wr_we_e4", {31'd0, mem_WE}, 32'd0);
        chk("wr_done", {31'd0, done0}, 32'd1);
        chk("wr_no_rv", {31'd0, rvalid0}, 32'd0);
        we0 = 0;

        // Late request: req1 raised during a port-0 burst.
        req0 = 1; burst0 = 1; adr0 = 10'h100;
        step();
        chk("late_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 0; burst0 = 0;
        step(); step();
        req1 = 1; adr1 = 10'h3FF;
        for (int e = 3; e <= 16; e++) begin
            step();
            chk("late_no_gnt1", {31'd0, gnt1}, 32'd0);
        end
        chk("late_done0", {31'd0, done0}, 32'd1);
        step();
        chk("late_gnt1", {31'd0, gnt1}, 32'd1);
        req1 = 0;
        step(); step(); step(); step();
        chk("late_done1", {31'd0, done1}, 32'd1);

        // Reset in the middle of a port-1 burst.
        req1 = 1; burst1 = 1; adr1 = 10'h0C8;
        step();
        chk("rb_gnt1", {31'd0, gnt1}, 32'd1);
        req1 = 0;
        for (int e = 1; e <= 8; e++) step();
        chk("rb_rv2", {31'd0, rvalid1}, 32'd1);
        chk("rb_widx2", {30'd0, word_idx}, 32'd1);
        RST = 1;
        step();
        chk_all_zero("rb_rst");
        req1 = 1; burst1 = 0; adr1 = 10'h077;
        step();
        chk("rb_rst_hold_done", {31'd0, done1}, 32'd0);
        RST = 0;
        step();
        chk("rb_fresh_gnt1", {31'd0, gnt1}, 32'd1);
        req1 = 0;
        step(); step(); step(); step();
        chk("rb_fresh_done1", {31'd0, done1}, 32'd1);
        chk("rb_fresh_widx", {30'd0, word_idx}, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
